// File: rtl/wb_write_buffer_if.sv
// Bus bundle for the writeback buffer: two request channels, the register-file
// write port and the forwarding lookup port.
interface wb_write_buffer_if;
    // A request transfers on a cycle where its valid and ready are both high;
    // valid may not depend on ready, and ready is only meaningful while valid is high.
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_reg;
    logic [15:0] mem_data;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_reg;
    logic [15:0] alu_data;
    logic        wb_stall;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic        WriteReg;
    logic [15:0] pending;
    logic [3:0]  lookup_reg1;
    logic [3:0]  lookup_reg2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [15:0] fwd_data1;
    logic [15:0] fwd_data2;

    modport slave (
        input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
               wb_stall, lookup_reg1, lookup_reg2,
        output mem_ready, alu_ready, DstReg, DstData, WriteReg, pending,
               fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );

    modport master (
        output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
               wb_stall, lookup_reg1, lookup_reg2,
        input  mem_ready, alu_ready, DstReg, DstData, WriteReg, pending,
               fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );
endinterface

// File: rtl/wb_write_buffer.sv
// Writeback buffer: a circular FIFO merging load and ALU results into a single
// register-file write port, with pending-register tracking and forwarding.
module wb_write_buffer #(
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    wb_write_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL = CW'(DEPTH - 1);

    logic [3:0]    reg_q  [DEPTH];
    logic [15:0]   data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          mem_rdy, alu_rdy;
    logic          mem_push, alu_push, write_en;
    logic [PW-1:0] alu_slot;
    logic [DEPTH-1:0] valid_ent;
    logic [15:0]   pend;
    logic          hit1, hit2;
    logic [15:0]   fdata1, fdata2;

    // Ready is judged on the current count only; a same-cycle pop earns no credit.
    // R0 writes are acknowledged but never stored.
    always_comb begin
        mem_rdy  = (count_q < FULL);
        mem_push = bus.mem_valid && mem_rdy && (bus.mem_reg != 4'd0);
        alu_rdy  = (count_q < AFULL) || ((count_q < FULL) && !mem_push);
        alu_push = bus.alu_valid && alu_rdy && (bus.alu_reg != 4'd0);
        write_en = (count_q != '0) && !bus.wb_stall;
        alu_slot = mem_push ? tail_q + PW'(1) : tail_q;
        tail_d   = tail_q + PW'(mem_push) + PW'(alu_push);
        head_d   = write_en ? head_q + PW'(1) : head_q;
        count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(write_en);
    end

    always_comb begin
        valid_ent = '0;
        pend      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            valid_ent[k] = {1'b0, PW'(k) - head_q} < count_q;
            if (valid_ent[k]) pend[reg_q[k]] = 1'b1;
        end
        pend[0] = 1'b0;
    end

    // Walk oldest to youngest so the last match (nearest the tail) wins.
    always_comb begin
        logic [PW-1:0] idx;
        hit1   = 1'b0;
        hit2   = 1'b0;
        fdata1 = '0;
        fdata2 = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (valid_ent[idx] && (bus.lookup_reg1 != 4'd0) && (reg_q[idx] == bus.lookup_reg1)) begin
                hit1   = 1'b1;
                fdata1 = data_q[idx];
            end
            if (valid_ent[idx] && (bus.lookup_reg2 != 4'd0) && (reg_q[idx] == bus.lookup_reg2)) begin
                hit2   = 1'b1;
                fdata2 = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset; occupancy is tracked by head/count alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (mem_push) begin
                reg_q[tail_q]  <= bus.mem_reg;
                data_q[tail_q] <= bus.mem_data;
            end
            if (alu_push) begin
                reg_q[alu_slot]  <= bus.alu_reg;
                data_q[alu_slot] <= bus.alu_data;
            end
        end
    end

    assign bus.mem_ready = mem_rdy;
    assign bus.alu_ready = alu_rdy;
    assign bus.WriteReg  = write_en;
    assign bus.DstReg    = (count_q != '0) ? reg_q[head_q]  : 4'd0;
    assign bus.DstData   = (count_q != '0) ? data_q[head_q] : 16'd0;
    assign bus.pending   = pend;
    assign bus.fwd_hit1  = hit1;
    assign bus.fwd_hit2  = hit2;
    assign bus.fwd_data1 = fdata1;
    assign bus.fwd_data2 = fdata2;
endmodule

// File: tb/tb_wb_write_buffer.sv
// Directed bench for wb_write_buffer (DEPTH=4): per-cycle handshake, forwarding
// and ordering checks with a scoreboard of expected register-file writes.
module tb_wb_write_buffer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [19:0] exp_q[$];

    wb_write_buffer_if bus ();

    wb_write_buffer #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic drive_mem(input logic v, input logic [3:0] r, input logic [15:0] d);
        bus.mem_valid = v;
        bus.mem_reg   = r;
        bus.mem_data  = d;
    endtask

    task automatic drive_alu(input logic v, input logic [3:0] r, input logic [15:0] d);
        bus.alu_valid = v;
        bus.alu_reg   = r;
        bus.alu_data  = d;
    endtask

    task automatic idle();
        drive_mem(1'b0, 4'd0, 16'd0);
        drive_alu(1'b0, 4'd0, 16'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr"},    32'(bus.WriteReg),  32'd0);
        check({tag, "_dreg"},  32'(bus.DstReg),    32'd0);
        check({tag, "_ddata"}, 32'(bus.DstData),   32'd0);
        check({tag, "_pend"},  32'(bus.pending),   32'd0);
        check({tag, "_hit1"},  32'(bus.fwd_hit1),  32'd0);
        check({tag, "_hit2"},  32'(bus.fwd_hit2),  32'd0);
        check({tag, "_fd1"},   32'(bus.fwd_data1), 32'd0);
        check({tag, "_fd2"},   32'(bus.fwd_data2), 32'd0);
        check({tag, "_mrdy"},  32'(bus.mem_ready), 32'd1);
        check({tag, "_ardy"},  32'(bus.alu_ready), 32'd1);
    endtask

    // scoreboard: every write the DUT commits must match the front of exp_q
    always @(negedge clk) begin
        #2;
        if (bus.WriteReg === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                check("wr_reg",  32'(bus.DstReg),  32'(e[19:16]));
                check("wr_data", 32'(bus.DstData), 32'(e[15:0]));
            end
        end
    end

    initial begin
        logic [3:0] wrap_regs [12];
        n_checks = 0;
        n_errors = 0;
        wrap_regs = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd15, 4'd4, 4'd6, 4'd8, 4'd10};
        rst = 1'b1;
        idle();
        bus.wb_stall    = 1'b0;
        bus.lookup_reg1 = 4'd0;
        bus.lookup_reg2 = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.lookup_reg1 = 4'd5;
        bus.lookup_reg2 = 4'd3;
        #1 check_reset_outputs("por");

        // single ALU write, one-cycle latency; enqueuing entry not yet visible
        @(negedge clk);
        drive_alu(1'b1, 4'd5, 16'h1234);
        exp_q.push_back({4'd5, 16'h1234});
        #1;
        check("t32_ardy", 32'(bus.alu_ready), 32'd1);
        check("t32_pend_excl", 32'(bus.pending), 32'h0000);
        check("t32_hit_excl", 32'(bus.fwd_hit1), 32'd0);
        @(negedge clk);
        idle();
        #1;
        check("t32_wr", 32'(bus.WriteReg), 32'd1);
        check("t32_dreg", 32'(bus.DstReg), 32'd5);
        check("t32_ddata", 32'(bus.DstData), 32'h1234);
        check("t32_pend", 32'(bus.pending), 32'h0020);
        check("t32_fd1", 32'(bus.fwd_data1), 32'h1234);
        @(negedge clk);
        #1;
        check("t32_wr_off", 32'(bus.WriteReg), 32'd0);
        check("t32_pend_off", 32'(bus.pending), 32'h0000);

        // simultaneous mem+alu to the same register under stall; youngest forwards
        @(negedge clk);
        bus.wb_stall = 1'b1;
        drive_mem(1'b1, 4'd3, 16'hAAAA);
        drive_alu(1'b1, 4'd3, 16'hBBBB);
        exp_q.push_back({4'd3, 16'hAAAA});
        exp_q.push_back({4'd3, 16'hBBBB});
        #1;
        check("t33_mrdy", 32'(bus.mem_ready), 32'd1);
        check("t33_ardy", 32'(bus.alu_ready), 32'd1);
        @(negedge clk);
        idle();
        bus.lookup_reg1 = 4'd3;
        bus.lookup_reg2 = 4'd4;
        #1;
        check("t33_pend", 32'(bus.pending), 32'h0008);
        check("t33_hit1", 32'(bus.fwd_hit1), 32'd1);
        check("t33_fd1", 32'(bus.fwd_data1), 32'hBBBB);
        check("t33_hit2", 32'(bus.fwd_hit2), 32'd0);
        check("t33_fd2", 32'(bus.fwd_data2), 32'h0000);
        check("t33_stall_wr", 32'(bus.WriteReg), 32'd0);
        check("t33_head", 32'(bus.DstData), 32'hAAAA);
        @(negedge clk);
        bus.wb_stall = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("t33_drained", 32'(exp_q.size()), 32'd0);
        check("t33_pend_off", 32'(bus.pending), 32'h0000);

        // R0 request is acknowledged and discarded
        @(negedge clk);
        drive_alu(1'b1, 4'd0, 16'hFFFF);
        bus.lookup_reg1 = 4'd0;
        #1 check("t36_ardy", 32'(bus.alu_ready), 32'd1);
        @(negedge clk);
        idle();
        #1;
        check("t36_wr", 32'(bus.WriteReg), 32'd0);
        check("t36_pend", 32'(bus.pending), 32'h0000);
        check("t36_hit", 32'(bus.fwd_hit1), 32'd0);

        // fill to DEPTH under stall, then release with requests held
        bus.wb_stall = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            drive_alu(1'b1, 4'(k), 16'h1000 + 16'(k));
            exp_q.push_back({4'(k), 16'h1000 + 16'(k)});
            #1 check("t34_fill_ardy", 32'(bus.alu_ready), 32'd1);
        end
        @(negedge clk);
        drive_alu(1'b1, 4'd9, 16'h9999);
        drive_mem(1'b1, 4'd6, 16'h6666);
        #1;
        check("t34_full_mrdy", 32'(bus.mem_ready), 32'd0);
        check("t34_full_ardy", 32'(bus.alu_ready), 32'd0);
        check("t34_full_pend", 32'(bus.pending), 32'h001E);
        @(negedge clk);
        bus.wb_stall = 1'b0;
        #1;
        check("t34_rel_mrdy", 32'(bus.mem_ready), 32'd0);
        check("t34_rel_ardy", 32'(bus.alu_ready), 32'd0);
        check("t34_rel_wr", 32'(bus.WriteReg), 32'd1);
        @(negedge clk);
        exp_q.push_back({4'd6, 16'h6666});
        #1;
        check("t34_b_mrdy", 32'(bus.mem_ready), 32'd1);
        check("t34_b_ardy", 32'(bus.alu_ready), 32'd0);
        @(negedge clk);
        drive_mem(1'b0, 4'd0, 16'd0);
        exp_q.push_back({4'd9, 16'h9999});
        #1 check("t34_c_ardy", 32'(bus.alu_ready), 32'd1);
        @(negedge clk);
        idle();
        repeat (5) @(negedge clk);
        #1;
        check("t34_drained", 32'(exp_q.size()), 32'd0);
        check("t34_pend_off", 32'(bus.pending), 32'h0000);

        // count=3: mem wins the last slot, alu follows next cycle
        bus.wb_stall = 1'b1;
        for (int k = 10; k <= 12; k++) begin
            @(negedge clk);
            drive_alu(1'b1, 4'(k), {8'(k), 8'(k)});
            exp_q.push_back({4'(k), {8'(k), 8'(k)}});
        end
        @(negedge clk);
        bus.wb_stall = 1'b0;
        bus.lookup_reg1 = 4'd11;
        drive_mem(1'b1, 4'd7, 16'h7777);
        drive_alu(1'b1, 4'd8, 16'h8888);
        exp_q.push_back({4'd7, 16'h7777});
        #1;
        check("t35_mrdy", 32'(bus.mem_ready), 32'd1);
        check("t35_ardy", 32'(bus.alu_ready), 32'd0);
        check("t35_hit1", 32'(bus.fwd_hit1), 32'd1);
        check("t35_fd1", 32'(bus.fwd_data1), 32'h0B0B);
        @(negedge clk);
        drive_mem(1'b0, 4'd0, 16'd0);
        exp_q.push_back({4'd8, 16'h8888});
        #1 check("t35_next_ardy", 32'(bus.alu_ready), 32'd1);
        @(negedge clk);
        idle();
        repeat (6) @(negedge clk);
        #1 check("t35_drained", 32'(exp_q.size()), 32'd0);

        // reset with 3 entries buffered drops them
        bus.wb_stall = 1'b1;
        for (int k = 13; k <= 15; k++) begin
            @(negedge clk);
            drive_alu(1'b1, 4'(k), 16'hC000 + 16'(k));
            exp_q.push_back({4'(k), 16'hC000 + 16'(k)});
        end
        @(negedge clk);
        idle();
        rst = 1'b1;
        bus.lookup_reg1 = 4'd13;
        bus.lookup_reg2 = 4'd14;
        #1 check("t37_pre_pend", 32'(bus.pending), 32'hE000);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1 check_reset_outputs("t37");
        bus.wb_stall = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1 check("t37_no_wr", 32'(bus.WriteReg), 32'd0);
        end

        // pointer wrap over 12 back-to-back transfers
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive_alu(1'b1, wrap_regs[i], 16'h5000 + 16'(i));
            exp_q.push_back({wrap_regs[i], 16'h5000 + 16'(i)});
            #1 check("wrap_ardy", 32'(bus.alu_ready), 32'd1);
        end
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        #1;
        check("wrap_drained", 32'(exp_q.size()), 32'd0);
        check("wrap_pend_off", 32'(bus.pending), 32'h0000);
        check("wrap_wr_off", 32'(bus.WriteReg), 32'd0);

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_write_buffer.md
WB_WRITE_BUFFER -- requirements
Module: wb_write_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of buffer entries; legal values are powers of two, 2 to 8.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, with all state updated on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports mem_valid / mem_ready, input / output, 1 bit each: load-writeback request handshake.
REQ-005 The block SHALL have ports mem_reg / mem_data, input, 4 bits / 16 bits: load destination register and load data.
REQ-006 The block SHALL have ports alu_valid / alu_ready, input / output, 1 bit each: ALU-writeback request handshake.
REQ-007 The block SHALL have ports alu_reg / alu_data, input, 4 bits / 16 bits: ALU destination register and ALU result.
REQ-008 The block SHALL have port wb_stall, input, 1 bit: when high, the register-file write is held off.
REQ-009 The block SHALL have ports DstReg / DstData / WriteReg, output, 4 / 16 / 1 bits: the register-file write port.
REQ-010 The block SHALL have port pending, output, 16 bits: bit i is high while a buffered write targets register i.
REQ-011 The block SHALL have ports lookup_reg1 / lookup_reg2, input, 4 bits each: forwarding lookup addresses.
REQ-012 The block SHALL have ports fwd_hit1 / fwd_hit2 (1 bit each) and fwd_data1 / fwd_data2 (16 bits each), output: forwarding results.

Function
REQ-013 The block SHALL implement a circular FIFO of DEPTH entries, each entry holding {reg[3:0], data[15:0]}, with head and tail pointers and a count of width log2(DEPTH)+1.
REQ-014 A request SHALL be accepted when both its valid and its ready are high in the same cycle.
REQ-015 A request with reg=0 SHALL be accepted (ready follows the normal rules) and then discarded, because R0 is hardwired to zero.
REQ-016 mem_ready SHALL equal (count < DEPTH), computed from the current-cycle count; it SHALL NOT take credit for a same-cycle drain.
REQ-017 alu_ready SHALL equal (count < DEPTH-1) OR ((count < DEPTH) AND NOT (mem_valid AND mem_ready AND mem_reg != 0)).
REQ-018 When both requests are accepted in the same cycle, the mem entry SHALL be enqueued first (older) and the alu entry second.
REQ-019 WriteReg SHALL equal (count != 0) AND NOT wb_stall; DstReg and DstData SHALL be the head entry's fields, and SHALL be 0 when count is 0.
REQ-020 The head entry SHALL be popped at the clock edge whenever WriteReg is high, giving at most one pop per cycle.
REQ-021 A request accepted at edge N into an empty, unstalled buffer SHALL appear on WriteReg in cycle N+1, giving 1-cycle latency.
REQ-022 When enqueue and pop occur in the same cycle, count SHALL change by (enqueued entries - 1); a full buffer SHALL still pop and SHALL accept nothing new that cycle.
REQ-023 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH and SHALL never underflow.
REQ-024 pending[i] SHALL be the OR over all valid entries whose reg equals i; pending[0] SHALL always be 0.
REQ-025 fwd_hit1 SHALL be high when lookup_reg1 != 0 and any valid entry matches it.
REQ-026 fwd_data1 SHALL be the data of the youngest matching entry (nearest the tail), and SHALL be 0 on a miss; port 2 SHALL behave identically.
REQ-027 pending and fwd_* SHALL reflect the current-cycle buffer contents; they SHALL include the head being written this cycle and SHALL exclude requests being enqueued this cycle.
REQ-028 While wb_stall is high, buffered data SHALL remain unchanged and enqueue SHALL continue subject to the ready rules.

Reset
REQ-029 When rst is high at a clock edge, count, head and tail SHALL be cleared to 0, and the clear SHALL override any same-cycle enqueue or pop.
REQ-030 In the cycle after reset, the outputs SHALL be: WriteReg=0, DstReg=0, DstData=0, pending=16'h0000, fwd_hit1=fwd_hit2=0, fwd_data1=fwd_data2=0, mem_ready=1, alu_ready=1.
REQ-031 A reset asserted while the buffer is non-empty SHALL drop all buffered writes, with no register-file write issued for them.

Verification
REQ-032 Empty buffer, alu_valid with reg=5, data=16'h1234 at edge N -> cycle N+1 shows WriteReg=1, DstReg=5, DstData=16'h1234, pending=16'h0020; cycle N+2 shows WriteReg=0, pending=0.
REQ-033 Simultaneous mem (reg 3, 16'hAAAA) and alu (reg 3, 16'hBBBB) requests with wb_stall=1 -> both accepted, pending[3]=1, lookup_reg1=3 gives fwd_hit1=1 and fwd_data1=16'hBBBB; after wb_stall drops, writes occur in order AAAA then BBBB.
REQ-034 wb_stall=1 with 4 ALU writes (DEPTH=4) -> count reaches 4, mem_ready=alu_ready=0; drop wb_stall with new requests held valid -> one pop per cycle, new request accepted in the first cycle after ready returns, write order preserved.
REQ-035 Count=3 with mem_valid (reg 7) and alu_valid (reg 8) both high -> mem accepted, alu_ready=0, alu held and accepted in the next cycle.
REQ-036 alu_valid with reg=0 -> accepted, no WriteReg pulse, pending stays 0, fwd_hit with lookup_reg=0 stays 0.
REQ-037 Buffer holding 3 entries with rst asserted for 1 cycle -> no further WriteReg pulses, all outputs match the post-reset values in REQ-030, and pointer wrap verified over more than 2*DEPTH subsequent transfers.
